// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage between EX_MEM and MEM_WB, little-endian assembly with sign/zero extension.
`ifndef idNOP
`define instIdxRange 5:0
`define idNOP 6'd0
`define idLB  6'd1
`define idLH  6'd2
`define idLW  6'd3
`define idLBU 6'd4
`define idLHU 6'd5
`define idSB  6'd6
`define idSH  6'd7
`define idSW  6'd8
`endif
module mem_stage (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [`instIdxRange] instIdx_in,
  input  logic [31:0]          memAddr_in,
  input  logic [31:0]          valStore_in,
  input  logic                 rdE_in,
  input  logic [4:0]           rdIdx_in,
  input  logic [31:0]          rdData_in,
  output logic                 mem_req_out,
  output logic                 mem_wr_out,
  output logic [31:0]          mem_addr_out,
  output logic [7:0]           mem_dout_out,
  input  logic                 mem_grant_in,
  input  logic [7:0]           mem_din_in,
  output logic                 valid_out,
  output logic                 rdE_out,
  output logic [4:0]           rdIdx_out,
  output logic [31:0]          rdData_out,
  output logic                 stall_out
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t              state_q, state_d;
  logic [2:0]          k_q, k_d, n_q, n_d, size_in;
  logic                load_q, load_d, cap_q, cap_d, is_load_in;
  logic [1:0]          lane_q, lane_d;
  logic [`instIdxRange] inst_q, inst_d;
  logic [31:0]         addr_q, addr_d, store_q, store_d, data_q, data_d;
  logic                rde_q, rde_d;
  logic [4:0]          idx_q, idx_d;
  logic                valid_q, valid_d, orde_q, orde_d;
  logic [4:0]          oidx_q, oidx_d;
  logic [31:0]         odata_q, odata_d, full, ext;
  logic                req, granted;
  always_comb begin
    size_in = 3'd0;
    is_load_in = 1'b0;
    case (instIdx_in)
      `idLB, `idLBU: begin size_in = 3'd1; is_load_in = 1'b1; end
      `idLH, `idLHU: begin size_in = 3'd2; is_load_in = 1'b1; end
      `idLW:         begin size_in = 3'd4; is_load_in = 1'b1; end
      `idSB:         size_in = 3'd1;
      `idSH:         size_in = 3'd2;
      `idSW:         size_in = 3'd4;
      default:       size_in = 3'd0;
    endcase
  end
  // the byte arriving this cycle is merged before extension so completion needs no extra cycle
  always_comb begin
    full = data_q;
    full[8*lane_q +: 8] = mem_din_in;
    ext = inst_q == `idLB  ? {{24{full[7]}}, full[7:0]} :
          inst_q == `idLH  ? {{16{full[15]}}, full[15:0]} :
          inst_q == `idLBU ? {24'd0, full[7:0]} :
          inst_q == `idLHU ? {16'd0, full[15:0]} : full;
  end
  assign req     = state_q == BUSY && k_q < n_q;
  assign granted = req && mem_grant_in;
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    load_d  = load_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    store_d = store_q;
    data_d  = data_q;
    rde_d   = rde_q;
    idx_d   = idx_q;
    orde_d  = orde_q;
    oidx_d  = oidx_q;
    odata_d = odata_q;
    valid_d = 1'b0;
    cap_d   = granted && load_q;
    lane_d  = k_q[1:0];
    if (valid_in && state_q == IDLE) begin
      if (size_in == 3'd0) begin
        valid_d = 1'b1;
        orde_d  = rdE_in;
        oidx_d  = rdIdx_in;
        odata_d = rdData_in;
      end else begin
        state_d = BUSY;
        k_d     = 3'd0;
        n_d     = size_in;
        load_d  = is_load_in;
        inst_d  = instIdx_in;
        addr_d  = memAddr_in;
        store_d = valStore_in;
        data_d  = 32'd0;
        rde_d   = rdE_in;
        idx_d   = rdIdx_in;
      end
    end
    if (granted) k_d = k_q + 3'd1;
    if (granted && !load_q && k_q == n_q - 3'd1) begin
      state_d = IDLE;
      valid_d = 1'b1;
      orde_d  = 1'b0;
      oidx_d  = idx_q;
      odata_d = 32'd0;
    end
    if (cap_q) data_d = full;
    if (cap_q && {1'b0, lane_q} == n_q - 3'd1) begin
      state_d = IDLE;
      valid_d = 1'b1;
      orde_d  = rde_q;
      oidx_d  = idx_q;
      odata_d = ext;
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      n_q     <= 3'd0;
      load_q  <= 1'b0;
      cap_q   <= 1'b0;
      lane_q  <= 2'd0;
      inst_q  <= '0;
      addr_q  <= 32'd0;
      store_q <= 32'd0;
      data_q  <= 32'd0;
      rde_q   <= 1'b0;
      idx_q   <= 5'd0;
      valid_q <= 1'b0;
      orde_q  <= 1'b0;
      oidx_q  <= 5'd0;
      odata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      load_q  <= load_d;
      cap_q   <= cap_d;
      lane_q  <= lane_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      data_q  <= data_d;
      rde_q   <= rde_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      orde_q  <= orde_d;
      oidx_q  <= oidx_d;
      odata_q <= odata_d;
    end
  end
  assign ready_out    = state_q == IDLE;
  assign stall_out    = state_q != IDLE;
  assign mem_req_out  = req;
  assign mem_wr_out   = req && !load_q;
  assign mem_addr_out = req ? addr_q + {29'd0, k_q} : 32'd0;
  assign mem_dout_out = req ? store_q[8*k_q[1:0] +: 8] : 8'd0;
  assign valid_out    = valid_q;
  assign rdE_out      = orde_q;
  assign rdIdx_out    = oidx_q;
  assign rdData_out   = odata_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus hand sequences against a byte-addressed memory model.
module tb_mem_stage;
  localparam logic [5:0] NOP = 6'd0, LB = 6'd1, LH = 6'd2, LW = 6'd3, LBU = 6'd4, LHU = 6'd5;
  localparam logic [5:0] SB = 6'd6, SH = 6'd7, SW = 6'd8, ADD = 6'd9;
  logic        clk_in = 1'b0, rst_in = 1'b0, valid_in = 1'b0, ready_out;
  logic [5:0]  instIdx_in = 6'd0;
  logic [31:0] memAddr_in = 32'd0, valStore_in = 32'd0, rdData_in = 32'd0;
  logic        rdE_in = 1'b0;
  logic [4:0]  rdIdx_in = 5'd0;
  logic        mem_req_out, mem_wr_out, mem_grant_in = 1'b1;
  logic [31:0] mem_addr_out;
  logic [7:0]  mem_dout_out, mem_din_in = 8'h00;
  logic        valid_out, rdE_out, stall_out;
  logic [4:0]  rdIdx_out;
  logic [31:0] rdData_out;
  int checks = 0, failures = 0;
  logic [7:0]  mem [2048] = '{default: 8'h00};
  logic [31:0] wlog_a [16], rlog_a [16];
  logic [7:0]  wlog_d [16];
  int wr_cnt = 0, rd_cnt = 0;

  mem_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
    .instIdx_in(instIdx_in), .memAddr_in(memAddr_in), .valStore_in(valStore_in),
    .rdE_in(rdE_in), .rdIdx_in(rdIdx_in), .rdData_in(rdData_in),
    .mem_req_out(mem_req_out), .mem_wr_out(mem_wr_out), .mem_addr_out(mem_addr_out),
    .mem_dout_out(mem_dout_out), .mem_grant_in(mem_grant_in), .mem_din_in(mem_din_in),
    .valid_out(valid_out), .rdE_out(rdE_out), .rdIdx_out(rdIdx_out),
    .rdData_out(rdData_out), .stall_out(stall_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [10:0] idx(logic [31:0] a);
    return {a[31], a[9:0]};
  endfunction

  always @(posedge clk_in) begin
    if (mem_req_out && mem_grant_in) begin
      if (mem_wr_out) begin
        mem[idx(mem_addr_out)] = mem_dout_out;
        wlog_a[wr_cnt % 16] = mem_addr_out;
        wlog_d[wr_cnt % 16] = mem_dout_out;
        wr_cnt = wr_cnt + 1;
      end else begin
        mem_din_in <= mem[idx(mem_addr_out)];
        rlog_a[rd_cnt % 16] = mem_addr_out;
        rd_cnt = rd_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] inst, input logic [31:0] addr, input logic [31:0] st,
                       input logic rde, input logic [4:0] ridx, input logic [31:0] rd);
    instIdx_in = inst; memAddr_in = addr; valStore_in = st;
    rdE_in = rde; rdIdx_in = ridx; rdData_in = rd; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (valid_out) begin
        lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic [5:0]  inst;
    logic [31:0] addr;
    logic [31:0] st;
    logic        rde;
    logic [4:0]  ridx;
    logic [31:0] rd;
    logic        erde;
    logic [31:0] edata;
    int          lat;
  } vec_t;
  vec_t v [12];

  initial begin
    int lat, w0, r0;
    v[0]  = '{SW,  32'h0000_0100, 32'h1122_3344, 1'b1, 5'd7, 32'h0,    1'b0, 32'h0000_0000, 4};
    v[1]  = '{SH,  32'h0000_0200, 32'h0000_FF80, 1'b1, 5'd8, 32'h0,    1'b0, 32'h0000_0000, 2};
    v[2]  = '{LH,  32'h0000_0200, 32'h0,         1'b1, 5'd5, 32'h0,    1'b1, 32'hFFFF_FF80, 3};
    v[3]  = '{LHU, 32'h0000_0200, 32'h0,         1'b1, 5'd6, 32'h0,    1'b1, 32'h0000_FF80, 3};
    v[4]  = '{SB,  32'h0000_0204, 32'hAAAA_AA7F, 1'b1, 5'd2, 32'h0,    1'b0, 32'h0000_0000, 1};
    v[5]  = '{LB,  32'h0000_0204, 32'h0,         1'b1, 5'd4, 32'h0,    1'b1, 32'h0000_007F, 2};
    v[6]  = '{LBU, 32'h0000_0201, 32'h0,         1'b1, 5'd9, 32'h0,    1'b1, 32'h0000_00FF, 2};
    v[7]  = '{LB,  32'h0000_0201, 32'h0,         1'b1, 5'd10, 32'h0,   1'b1, 32'hFFFF_FFFF, 2};
    v[8]  = '{LW,  32'h0000_0100, 32'h0,         1'b1, 5'd11, 32'h0,   1'b1, 32'h1122_3344, 5};
    v[9]  = '{SW,  32'hFFFF_FFFE, 32'hDEAD_BEEF, 1'b0, 5'd12, 32'h0,   1'b0, 32'h0000_0000, 4};
    v[10] = '{NOP, 32'h0000_0300, 32'h0,         1'b1, 5'd13, 32'h1234, 1'b1, 32'h0000_1234, 0};
    v[11] = '{LW,  32'h0000_0100, 32'h0,         1'b0, 5'd14, 32'h0,   1'b0, 32'h1122_3344, 5};

    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_req", {31'd0, mem_req_out}, 32'd0);
    check("rst_addr", mem_addr_out, 32'd0);
    check("rst_rddata", rdData_out, 32'd0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    // back-to-back ALU bundles
    instIdx_in = ADD; rdIdx_in = 5'd3; rdE_in = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdData_in = 32'd5 + i;
      @(posedge clk_in); #1;
      check("add_valid", {31'd0, valid_out}, 32'd1);
      check("add_data", rdData_out, 32'd5 + i);
      check("add_idx", {27'd0, rdIdx_out}, 32'd3);
      check("add_stall", {31'd0, stall_out}, 32'd0);
    end
    valid_in = 1'b0;
    @(posedge clk_in); #1;
    check("add_valid_end", {31'd0, valid_out}, 32'd0);

    w0 = wr_cnt;
    for (int i = 0; i < 12; i++) begin
      issue(v[i].inst, v[i].addr, v[i].st, v[i].rde, v[i].ridx, v[i].rd);
      wait_valid(lat);
      check($sformatf("vec%0d_lat", i), lat, v[i].lat);
      check($sformatf("vec%0d_rde", i), {31'd0, rdE_out}, {31'd0, v[i].erde});
      check($sformatf("vec%0d_idx", i), {27'd0, rdIdx_out}, {27'd0, v[i].ridx});
      check($sformatf("vec%0d_data", i), rdData_out, v[i].edata);
      check($sformatf("vec%0d_stall", i), {31'd0, stall_out}, 32'd0);
      @(posedge clk_in); #1;
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sw_waddr%0d", i), wlog_a[(w0 + i) % 16], 32'h100 + i);
      check($sformatf("sw_wdata%0d", i), {24'd0, wlog_d[(w0 + i) % 16]}, {24'd0, 8'h44 - 8'h11 * i[7:0]});
    end

    // LW wrapping past 0xFFFFFFFF with the grant withheld two cycles on byte 1
    r0 = rd_cnt;
    issue(LW, 32'hFFFF_FFFE, 32'h0, 1'b1, 5'd20, 32'h0);
    @(posedge clk_in); #1;
    mem_grant_in = 1'b0;
    check("wrap_hold_addr0", mem_addr_out, 32'hFFFF_FFFF);
    check("wrap_hold_req0", {31'd0, mem_req_out}, 32'd1);
    @(posedge clk_in); #1;
    check("wrap_hold_addr1", mem_addr_out, 32'hFFFF_FFFF);
    check("wrap_hold_valid", {31'd0, valid_out}, 32'd0);
    @(posedge clk_in); #1;
    mem_grant_in = 1'b1;
    wait_valid(lat);
    check("wrap_lat", lat, 4);
    check("wrap_data", rdData_out, 32'hDEAD_BEEF);
    check("wrap_rde", {31'd0, rdE_out}, 32'd1);
    check("wrap_raddr0", rlog_a[r0 % 16], 32'hFFFF_FFFE);
    check("wrap_raddr1", rlog_a[(r0 + 1) % 16], 32'hFFFF_FFFF);
    check("wrap_raddr2", rlog_a[(r0 + 2) % 16], 32'h0000_0000);
    check("wrap_raddr3", rlog_a[(r0 + 3) % 16], 32'h0000_0001);
    @(posedge clk_in); #1;

    // asynchronous reset while byte 2 of an LW is outstanding
    issue(LW, 32'h0000_0100, 32'h0, 1'b1, 5'd21, 32'h0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    check("rstmid_req_before", {31'd0, mem_req_out}, 32'd1);
    check("rstmid_addr_before", mem_addr_out, 32'h0000_0102);
    #2 rst_in = 1'b0;
    #1;
    check("rstmid_req", {31'd0, mem_req_out}, 32'd0);
    check("rstmid_valid", {31'd0, valid_out}, 32'd0);
    check("rstmid_stall", {31'd0, stall_out}, 32'd0);
    check("rstmid_ready", {31'd0, ready_out}, 32'd1);
    #2 rst_in = 1'b1;
    @(posedge clk_in); #1;
    check("rstmid_no_valid", {31'd0, valid_out}, 32'd0);
    issue(LB, 32'h0000_0204, 32'h0, 1'b1, 5'd22, 32'h0);
    wait_valid(lat);
    check("post_rst_lb_lat", lat, 2);
    check("post_rst_lb_data", rdData_out, 32'h0000_007F);
    check("post_rst_lb_idx", {27'd0, rdIdx_out}, 32'd22);
    @(posedge clk_in); #1;
    issue(LHU, 32'h0000_0200, 32'h0, 1'b1, 5'd23, 32'h0);
    wait_valid(lat);
    check("post_rst_lhu_lat", lat, 3);
    check("post_rst_lhu_data", rdData_out, 32'h0000_FF80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
